// File: rtl/mem_bist_pkg.sv
// mem_bist shared types: FSM states, default geometry, counter width.
// Optional early-stop build: MEM_BIST_STOP_ON_FAIL_EN.
package mem_bist_pkg;
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 8;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_UP,
    S_RW_UP_R,
    S_RW_UP_W,
    S_R_DN,
    S_DONE
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction
endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter with terminal flags.
// Priority: load, then increment, then decrement.
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_at_max,
  output logic              o_at_zero
);
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else if (i_dec) begin
      r_addr <= r_addr - ADDR_W'(1);
    end
  end

  assign o_addr    = r_addr;
  assign o_at_max  = &r_addr;
  assign o_at_zero = ~|r_addr;
endmodule

// File: rtl/mem_bist.sv
// Three-element March BIST sequencer with first-fail capture.
// MEM_BIST_STOP_ON_FAIL_EN: end the test on the first mismatch.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    pattern,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_exp,
  output logic [DATA_W-1:0]    fail_act,
  output logic                 wen,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W-1:0]    rdata
);
  state_t                r_state;
  logic [DATA_W-1:0]     r_pat;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_pass;
  logic [ERR_CNT_W-1:0]  r_err;
  logic [ADDR_W-1:0]     r_fa;
  logic [DATA_W-1:0]     r_fe;
  logic [DATA_W-1:0]     r_fact;

  logic [ADDR_W-1:0]     w_addr;
  logic                  w_at_max;
  logic                  w_at_zero;
  logic                  w_ld;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_rd;
  logic [DATA_W-1:0]     w_exp;
  logic                  w_mis;
  logic                  w_stop;
  logic [ERR_CNT_W-1:0]  w_err_nxt;

  assign w_rd  = (r_state == S_RW_UP_R) || (r_state == S_R_DN);
  assign w_exp = (r_state == S_R_DN) ? ~r_pat : r_pat;
  assign w_mis = w_rd && (rdata != w_exp);
  assign w_err_nxt = w_mis ? sat_inc(r_err) : r_err;

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif

  // RW_UP_W at max falls into R_DN with the address already at max.
  always_comb begin
    w_ld  = 1'b0;
    w_inc = 1'b0;
    w_dec = 1'b0;
    case (r_state)
      S_IDLE:    w_ld = start;
      S_W_UP: begin
        w_ld  = w_at_max;
        w_inc = !w_at_max;
      end
      S_RW_UP_W: w_inc = !w_at_max;
      S_R_DN:    w_dec = !w_at_zero && !w_stop;
      default: ;
    endcase
  end

  mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ld),
    .i_load_val ('0),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .o_addr     (w_addr),
    .o_at_max   (w_at_max),
    .o_at_zero  (w_at_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_wdata <= '0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fa    <= '0;
      r_fe    <= '0;
      r_fact  <= '0;
    end else begin
      if (w_mis) begin
        r_err <= w_err_nxt;
        if (r_err == '0) begin
          r_fa   <= w_addr;
          r_fe   <= w_exp;
          r_fact <= rdata;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_W_UP;
            r_pat   <= pattern;
            r_wdata <= pattern;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fa    <= '0;
            r_fe    <= '0;
            r_fact  <= '0;
          end
        end
        S_W_UP: begin
          if (w_at_max) r_state <= S_RW_UP_R;
        end
        S_RW_UP_R: begin
          if (w_stop) begin
            r_state <= S_DONE;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_state <= S_RW_UP_W;
            r_wdata <= ~r_pat;
          end
        end
        S_RW_UP_W: begin
          r_state <= w_at_max ? S_R_DN : S_RW_UP_R;
        end
        S_R_DN: begin
          if (w_at_zero || w_stop) begin
            r_state <= S_DONE;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_W_UP) || (r_state == S_RW_UP_R) ||
                (r_state == S_RW_UP_W) || (r_state == S_R_DN);
  assign done = (r_state == S_DONE);
  assign wen  = (r_state == S_W_UP) || (r_state == S_RW_UP_W);
  assign addr      = w_addr;
  assign wdata     = r_wdata;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_addr = r_fa;
  assign fail_exp  = r_fe;
  assign fail_act  = r_fact;
endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist with a faultable memory model.
// Expectations follow MEM_BIST_STOP_ON_FAIL_EN when defined.
module tb_mem_bist;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, pass, wen;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr, addr;
  logic [DW-1:0] fail_exp, fail_act, wdata, rdata;

  always #5 clk = ~clk;

  mem_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_act(fail_act), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata)
  );

  // fmode 1: bit 3 of 0x2A5 stuck at 0; fmode 2: 0x2xx writes land in 0x1xx
  logic [DW-1:0] mem [N];
  int fmode = 0;
  bit clr = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (wen) begin
      if (fmode == 2 && addr[9:8] == 2'b10)
        mem[{2'b01, addr[7:0]}] <= wdata;
      else
        mem[addr] <= wdata;
    end
  end

  assign rdata = (fmode == 1 && addr == 10'h2A5) ?
                 (mem[addr] & 8'hF7) : mem[addr];

  typedef struct {
    int busy_n;
    int wen_n;
    int pass;
    int err;
    int fa;
    int fe;
    int fact;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int busy_n = 0;
  int wen_n = 0;
  bit pb = 1'b0;
  bit pd = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (busy && !pb) begin
      busy_n = 1;
      wen_n  = int'(wen);
    end else if (busy) begin
      busy_n++;
      wen_n += int'(wen);
    end
    if (done) begin
      done_total++;
      chk("done_width", int'(pd), 0);
      chk("done_after_busy", int'(pb), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with no run pending");
      end else begin
        m_e = sb.pop_front();
        chk("busy_cycles", busy_n, m_e.busy_n);
        chk("wen_cycles", wen_n, m_e.wen_n);
        chk("pass", int'(pass), m_e.pass);
        chk("err_cnt", int'(err_cnt), m_e.err);
        chk("fail_addr", int'(fail_addr), m_e.fa);
        chk("fail_exp", int'(fail_exp), m_e.fe);
        chk("fail_act", int'(fail_act), m_e.fact);
      end
    end
    pb = busy;
    pd = done;
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one");
    end
  endtask

  task automatic prep(input int fm);
    @(negedge clk);
    clr   = 1'b1;
    fmode = fm;
    @(negedge clk);
    clr   = 1'b0;
  endtask

  task automatic run(input logic [7:0] p, input int fm, input exp_t e);
    prep(fm);
    sb.push_back(e);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done();
    @(negedge clk);
    chk("pass_hold", int'(pass), e.pass);
  endtask

  initial begin
    exp_t e;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fail_addr", int'(fail_addr), 0);
    chk("rst_fail_exp", int'(fail_exp), 0);
    chk("rst_fail_act", int'(fail_act), 0);
    chk("rst_wen", int'(wen), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_wdata", int'(wdata), 0);
    rst = 1'b0;

    e = '{4096, 2048, 1, 0, 0, 0, 0};
    run(8'h5A, 0, e);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
    e = '{3419, 2048, 0, 1, 'h2A5, 'hFF, 'hF7};
`else
    e = '{4096, 2048, 0, 1, 'h2A5, 'hFF, 'hF7};
`endif
    run(8'h00, 1, e);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
    e = '{2049, 1536, 0, 1, 'h200, 'h5A, 'h00};
`else
    e = '{4096, 2048, 0, 255, 'h200, 'h5A, 'h00};
`endif
    run(8'h5A, 2, e);

    prep(0);
    pattern = 8'h33;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (1499) @(negedge clk);
    chk("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wen", int'(wen), 0);
    chk("mid_rst_err", int'(err_cnt), 0);
    d0 = done_total;
    repeat (5000) @(negedge clk);
    chk("no_done_after_rst", done_total, d0);

    prep(0);
    e = '{4096, 2048, 1, 0, 0, 0, 0};
    sb.push_back(e);
    pattern = 8'hC3;
    start   = 1'b1;
    wait_done();
    @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
